// File: rtl/neuron_trainer.sv
// Single-neuron perceptron trainer: latches one training sample, then runs
// TRAIN_ITERATIONS predict/update passes of the perceptron rule and parks in DONE.
module neuron_trainer #(
  parameter int SIGN             = 1,
  parameter int Q_M              = 15,
  parameter int Q_N              = 16,
  parameter int TRAIN_ITERATIONS = 5,
  parameter logic signed [SIGN+Q_M+Q_N-1:0] LEARNING_RATE    = 32'h0001_0000,
  parameter logic signed [SIGN+Q_M+Q_N-1:0] INIT_WEIGHT_1    = 32'h0001_0000,
  parameter logic signed [SIGN+Q_M+Q_N-1:0] INIT_WEIGHT_2    = 32'h0001_0000,
  parameter logic signed [SIGN+Q_M+Q_N-1:0] INIT_WEIGHT_BIAS = 32'h0000_4000,
  parameter logic signed [SIGN+Q_M+Q_N-1:0] BIAS             = 32'h0001_0000
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic signed [SIGN+Q_M+Q_N-1:0] train_x1_in,
  input  logic signed [SIGN+Q_M+Q_N-1:0] train_x2_in,
  input  logic signed [SIGN+Q_M+Q_N-1:0] train_out_in,
  input  logic                          valid_i
);

  localparam int W = SIGN + Q_M + Q_N;
  localparam logic signed [W-1:0] ONE = W'(1) << Q_N;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREDICT = 2'd1,
    UPDATE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q;
  logic signed [W-1:0]   weight_1_q;
  logic signed [W-1:0]   weight_2_q;
  logic signed [W-1:0]   weight_bias_q;
  logic signed [W-1:0]   x1_q;
  logic signed [W-1:0]   x2_q;
  logic signed [W-1:0]   target_q;
  logic signed [W-1:0]   prediction_q;
  logic [15:0]           iter_count_q;
  logic                  done_q;

  // Fixed-point multiply: full-precision signed product, rescaled, wrapped to W bits.
  function automatic logic signed [W-1:0] mul(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] scaled;
    prod   = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    scaled = prod >>> Q_N;
    return scaled[W-1:0];
  endfunction

  logic signed [W-1:0] sum;
  logic signed [W-1:0] err;
  logic signed [W-1:0] k;
  logic [15:0]         iter_next;

  assign sum       = mul(weight_1_q, x1_q) + mul(weight_2_q, x2_q) + mul(weight_bias_q, BIAS);
  assign err       = target_q - prediction_q;
  assign k         = mul(LEARNING_RATE, err);
  assign iter_next = iter_count_q + 16'd1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      weight_1_q    <= INIT_WEIGHT_1;
      weight_2_q    <= INIT_WEIGHT_2;
      weight_bias_q <= INIT_WEIGHT_BIAS;
      x1_q          <= '0;
      x2_q          <= '0;
      target_q      <= '0;
      prediction_q  <= '0;
      iter_count_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            x1_q         <= train_x1_in;
            x2_q         <= train_x2_in;
            target_q     <= train_out_in;
            iter_count_q <= '0;
            state_q      <= PREDICT;
          end
        end
        PREDICT: begin
          // Step activation: non-negative weighted sum fires 1.0.
          prediction_q <= sum[W-1] ? '0 : ONE;
          state_q      <= UPDATE;
        end
        UPDATE: begin
          weight_1_q    <= weight_1_q + mul(k, x1_q);
          weight_2_q    <= weight_2_q + mul(k, x2_q);
          weight_bias_q <= weight_bias_q + mul(k, BIAS);
          iter_count_q  <= iter_next;
          if (iter_next == 16'(TRAIN_ITERATIONS)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= PREDICT;
          end
        end
        DONE: begin
          // Terminal: only reset leaves this state.
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_trainer.sv
// Self-checking bench for neuron_trainer: directed scenarios plus randomized
// samples compared against a plain-arithmetic perceptron model.
module tb_neuron_trainer;

  localparam int ITERS     = 5;
  localparam int LR        = 32'h0001_0000;
  localparam int INIT_W1   = 32'h0001_0000;
  localparam int INIT_W2   = 32'h0001_0000;
  localparam int INIT_WB   = 32'h0000_4000;
  localparam int BIAS_V    = 32'h0001_0000;
  localparam int ONE       = 32'h0001_0000;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] train_x1_in;
  logic [31:0] train_x2_in;
  logic [31:0] train_out_in;
  logic        valid_i;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  neuron_trainer dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .train_x1_in  (train_x1_in),
    .train_x2_in  (train_x2_in),
    .train_out_in (train_out_in),
    .valid_i      (valid_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int fx_mul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  // Reference: apply the perceptron rule ITERS times with ordinary integer math.
  task automatic model_train(input int x1, input int x2, input int t,
                             output int w1, output int w2, output int wb);
    int s, pred, k;
    w1 = INIT_W1; w2 = INIT_W2; wb = INIT_WB;
    for (int i = 0; i < ITERS; i++) begin
      s    = fx_mul(w1, x1) + fx_mul(w2, x2) + fx_mul(wb, BIAS_V);
      pred = (s >= 0) ? ONE : 0;
      k    = fx_mul(LR, t - pred);
      w1   = w1 + fx_mul(k, x1);
      w2   = w2 + fx_mul(k, x2);
      wb   = wb + fx_mul(k, BIAS_V);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  // Present a sample for one edge and then wait, bounded, for done_q.
  task automatic run_sample(input int x1, input int x2, input int t, input string name);
    int n;
    train_x1_in = x1; train_x2_in = x2; train_out_in = t; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    n = 0;
    while (dut.done_q !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (dut.done_q !== 1'b1) begin
      failed++;
      $display("FAIL %s done_timeout: done_q=%b required 1 within 40 cycles", name, dut.done_q);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; valid_i = 1'b1;
    train_x1_in = 32'h0003_0000; train_x2_in = 32'h0003_0000; train_out_in = ONE;
    step();
    step();
    tests_run++;
    if (dut.state_q !== ST_IDLE || dut.done_q !== 1'b0 || dut.iter_count_q !== 16'd0) begin
      failed++;
      $display("FAIL reset_ctrl: state=%0d done=%b iter=%0d required 0/0/0",
               dut.state_q, dut.done_q, dut.iter_count_q);
    end
    tests_run++;
    if (dut.weight_1_q !== INIT_W1 || dut.weight_2_q !== INIT_W2 || dut.weight_bias_q !== INIT_WB) begin
      failed++;
      $display("FAIL reset_weights: w1=%h w2=%h wb=%h required %h %h %h",
               dut.weight_1_q, dut.weight_2_q, dut.weight_bias_q, INIT_W1, INIT_W2, INIT_WB);
    end
    tests_run++;
    if (dut.x1_q !== 0 || dut.x2_q !== 0 || dut.target_q !== 0 || dut.prediction_q !== 0) begin
      failed++;
      $display("FAIL reset_data: x1=%h x2=%h t=%h p=%h required all 0",
               dut.x1_q, dut.x2_q, dut.target_q, dut.prediction_q);
    end
    reset_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic test_idle_hold();
    do_reset();
    train_x1_in = 32'h0002_0000;
    for (int i = 0; i < 30; i++) step();
    tests_run++;
    if (dut.state_q !== ST_IDLE || dut.weight_1_q !== INIT_W1 || dut.weight_bias_q !== INIT_WB) begin
      failed++;
      $display("FAIL idle_hold: state=%0d w1=%h wb=%h required 0 %h %h",
               dut.state_q, dut.weight_1_q, dut.weight_bias_q, INIT_W1, INIT_WB);
    end
  endtask

  // Exact latency: done_q low after 10 edges from capture, high on the 11th.
  task automatic test_target_one();
    do_reset();
    train_x1_in = ONE; train_x2_in = ONE; train_out_in = ONE; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) step();
    tests_run++;
    if (dut.done_q !== 1'b0) begin
      failed++;
      $display("FAIL latency_early: done_q=%b required 0 after 10 edges", dut.done_q);
    end
    step();
    tests_run++;
    if (dut.done_q !== 1'b1 || dut.state_q !== ST_DONE || dut.iter_count_q !== 16'(ITERS)) begin
      failed++;
      $display("FAIL latency_done: done=%b state=%0d iter=%0d required 1/3/%0d",
               dut.done_q, dut.state_q, dut.iter_count_q, ITERS);
    end
    tests_run++;
    if (dut.weight_1_q !== 32'h0001_0000 || dut.weight_2_q !== 32'h0001_0000 ||
        dut.weight_bias_q !== 32'h0000_4000 || dut.prediction_q !== ONE) begin
      failed++;
      $display("FAIL target_one: w1=%h w2=%h wb=%h p=%h required 00010000 00010000 00004000 00010000",
               dut.weight_1_q, dut.weight_2_q, dut.weight_bias_q, dut.prediction_q);
    end
  endtask

  task automatic test_target_zero();
    do_reset();
    run_sample(ONE, ONE, 0, "target_zero");
    tests_run++;
    if (dut.weight_1_q !== 32'h0 || dut.weight_2_q !== 32'h0 || dut.weight_bias_q !== 32'hFFFF_4000 ||
        dut.prediction_q !== 32'h0 || dut.iter_count_q !== 16'(ITERS)) begin
      failed++;
      $display("FAIL target_zero: w1=%h w2=%h wb=%h p=%h iter=%0d required 0 0 ffff4000 0 %0d",
               dut.weight_1_q, dut.weight_2_q, dut.weight_bias_q, dut.prediction_q,
               dut.iter_count_q, ITERS);
    end
  endtask

  // Continues from DONE left by test_target_zero.
  task automatic test_done_hold();
    train_x1_in = 32'h0004_0000; train_x2_in = 32'hFFFC_0000; train_out_in = ONE; valid_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    valid_i = 1'b0;
    tests_run++;
    if (dut.state_q !== ST_DONE || dut.done_q !== 1'b1 || dut.weight_1_q !== 32'h0 ||
        dut.weight_2_q !== 32'h0 || dut.weight_bias_q !== 32'hFFFF_4000 || dut.x1_q !== ONE) begin
      failed++;
      $display("FAIL done_hold: state=%0d done=%b w1=%h w2=%h wb=%h x1=%h required 3 1 0 0 ffff4000 %h",
               dut.state_q, dut.done_q, dut.weight_1_q, dut.weight_2_q, dut.weight_bias_q,
               dut.x1_q, ONE);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    train_x1_in = ONE; train_x2_in = ONE; train_out_in = 0; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset_i = 1'b1; valid_i = 1'b1;
    step();
    reset_i = 1'b0; valid_i = 1'b0;
    tests_run++;
    if (dut.state_q !== ST_IDLE || dut.done_q !== 1'b0 || dut.iter_count_q !== 16'd0 ||
        dut.weight_1_q !== INIT_W1 || dut.weight_2_q !== INIT_W2 || dut.weight_bias_q !== INIT_WB) begin
      failed++;
      $display("FAIL reset_mid: state=%0d done=%b iter=%0d w1=%h w2=%h wb=%h required IDLE/0/0/init",
               dut.state_q, dut.done_q, dut.iter_count_q, dut.weight_1_q, dut.weight_2_q,
               dut.weight_bias_q);
    end
    run_sample(ONE, ONE, 0, "restart");
    tests_run++;
    if (dut.weight_1_q !== 32'h0 || dut.weight_bias_q !== 32'hFFFF_4000) begin
      failed++;
      $display("FAIL restart: w1=%h wb=%h required 0 ffff4000", dut.weight_1_q, dut.weight_bias_q);
    end
  endtask

  task automatic test_input_change();
    int e1, e2, eb, x1, x2;
    x1 = 32'hFFFE_8000; x2 = 32'h0000_8000;
    model_train(x1, x2, 0, e1, e2, eb);
    do_reset();
    train_x1_in = x1; train_x2_in = x2; train_out_in = 0; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    step();
    train_x1_in = 32'h0005_0000; train_x2_in = 32'hFFF0_0000; train_out_in = ONE;
    for (int i = 0; i < 12; i++) step();
    tests_run++;
    if (dut.done_q !== 1'b1 || dut.weight_1_q !== e1 || dut.weight_2_q !== e2 || dut.weight_bias_q !== eb) begin
      failed++;
      $display("FAIL input_change: done=%b w1=%h w2=%h wb=%h required 1 %h %h %h",
               dut.done_q, dut.weight_1_q, dut.weight_2_q, dut.weight_bias_q, e1, e2, eb);
    end
  endtask

  // valid_i already high as reset releases: capture on the first free edge.
  task automatic test_back_to_back();
    int e1, e2, eb;
    model_train(32'h0001_8000, 32'hFFFF_0000, ONE, e1, e2, eb);
    reset_i = 1'b1;
    train_x1_in = 32'h0001_8000; train_x2_in = 32'hFFFF_0000; train_out_in = ONE; valid_i = 1'b1;
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 11; i++) step();
    tests_run++;
    if (dut.done_q !== 1'b1 || dut.weight_1_q !== e1 || dut.weight_2_q !== e2 || dut.weight_bias_q !== eb) begin
      failed++;
      $display("FAIL back_to_back: done=%b w1=%h w2=%h wb=%h required 1 %h %h %h",
               dut.done_q, dut.weight_1_q, dut.weight_2_q, dut.weight_bias_q, e1, e2, eb);
    end
    for (int i = 0; i < 10; i++) step();
    valid_i = 1'b0;
    tests_run++;
    if (dut.state_q !== ST_DONE || dut.weight_1_q !== e1 || dut.iter_count_q !== 16'(ITERS)) begin
      failed++;
      $display("FAIL valid_level_no_restart: state=%0d w1=%h iter=%0d required 3 %h %0d",
               dut.state_q, dut.weight_1_q, dut.iter_count_q, e1, ITERS);
    end
  endtask

  task automatic test_random();
    int x1, x2, t, e1, e2, eb;
    for (int n = 0; n < 40; n++) begin
      x1 = int'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      x2 = int'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      t  = ($urandom_range(0, 1) == 1) ? ONE : 0;
      model_train(x1, x2, t, e1, e2, eb);
      do_reset();
      run_sample(x1, x2, t, "random");
      tests_run++;
      if (dut.weight_1_q !== e1 || dut.weight_2_q !== e2 || dut.weight_bias_q !== eb) begin
        failed++;
        $display("FAIL random[%0d] x1=%h x2=%h t=%h: w1=%h w2=%h wb=%h required %h %h %h",
                 n, x1, x2, t, dut.weight_1_q, dut.weight_2_q, dut.weight_bias_q, e1, e2, eb);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0;
    train_x1_in = '0; train_x2_in = '0; train_out_in = '0;
    test_reset();
    test_idle_hold();
    test_target_one();
    test_target_zero();
    test_done_hold();
    test_reset_mid();
    test_input_change();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
